product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential accumulate stage placed directly downstream of the 8x8 unsigned array multiplier. It consumes one 16-bit product per cycle over a valid/ready handshake and sums a burst of products terminated by a `last` flag. It emits the burst total, the term count and an overflow flag over a second valid/ready handshake. Together with the multiplier it forms the dot-product / MAC path of the functional-unit set.

## Interface
- `ACC_WIDTH`, default 24: accumulator and result width in bits. Legal range is 16 to 32.
- `CNT_WIDTH`, default 8: width of the term counter.
- `SATURATE`, default 1: overflow handling. 1 clamps to the all-ones value; 0 wraps modulo 2^ACC_WIDTH.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `in_valid`  in  1: `in_prod` and `in_last` are valid.
- `in_ready`  out  1: the block can accept a beat this cycle.
- `in_prod`  in  16: unsigned product, taken from the multiplier's `Prod`.
- `in_last`  in  1: this beat ends the current burst.
- `out_valid`  out  1: a result is held on the `out_*` outputs.
- `out_ready`  in  1: the downstream stage takes the result.
- `out_sum`  out  ACC_WIDTH: burst total.
- `out_count`  out  CNT_WIDTH: number of beats in the burst. Saturates at 2^CNT_WIDTH-1.
- `out_ovf`  out  1: at least one accumulation in the burst overflowed.

## Operation
- **Internal registers:** `acc` (ACC_WIDTH), `cnt` (CNT_WIDTH), `ovf` (1), output registers, and a 1-bit state.
- **States:**
  - ACC: no result pending.
  - HOLD: result pending on the outputs.
- **Transitions:**
  - ACC to HOLD: a beat with `in_last=1` is accepted.
  - HOLD to ACC: `out_ready=1` and no last beat is accepted in the same cycle.
  - HOLD stays HOLD when a new last beat is accepted while the old result is consumed. The new result replaces the old one.
- **Ready:** `in_ready = (state==ACC) || out_ready`. The `out_ready` term makes HOLD-with-consume fully pipelined. `in_ready` is forced to 0 while `rst_n=0`.
- **Accept:** `in_valid && in_ready`. Per accepted beat:
  - Compute `sum = acc + zero_extend(in_prod)` at ACC_WIDTH+1 bits.
  - Carry out set: `ovf_next=1`. The value becomes all-ones if SATURATE=1, otherwise `sum[ACC_WIDTH-1:0]`.
  - After saturation, `acc` holds at all-ones. Further beats keep it there and keep `ovf` set.
  - `cnt_next = cnt+1`, saturating at the maximum.
- **Non-last beat:** `acc`, `cnt` and `ovf` take the next values.
- **Last beat:**
  - `out_sum`, `out_count` and `out_ovf` load the next values.
  - `acc`, `cnt` and `ovf` clear to 0, so the next burst starts fresh.
- **Idle cycles:** no accept means `acc`, `cnt` and `ovf` hold. Bubbles inside a burst are allowed.
- **Output stability:** `out_*` are stable while `out_valid=1 && out_ready=0`.
- **Reset:** `out_valid=0`, `out_sum=0`, `out_count=0`, `out_ovf=0`, `acc=0`, `cnt=0`, `ovf=0`, state ACC.
  - A reset mid-burst discards the partial sum.
  - A reset during HOLD drops the pending result.

## Timing
- **Latency:** `out_valid` rises on the edge that accepts the last beat, so it is visible the cycle after `in_valid && in_last` is sampled.
- **Single-beat burst:** a beat with `in_last=1` and nothing before it gives a result equal to `in_prod`, with count 1.
- **Throughput:** one beat per cycle. There is no gap between bursts when `out_ready=1`.
- **Backpressure:** with `out_ready=0` in HOLD, `in_ready=0` and the input stalls.
- **Release:** `out_ready` asserted in HOLD with no new last beat gives `out_valid=0` the next cycle.
- **Combinational paths:** `out_ready` to `in_ready` only. No combinational path from `in_*` to `out_*`.
- **Reset timing:** takes effect at the first rising edge with `rst_n=0`. Normal operation resumes on the first edge with `rst_n=1`.

## Test plan
- **Basic burst:** defaults. Beats 255*255 (65025), 65025, then 65025 with last, `out_ready=1`.
  - Expect `out_sum=195075`, `out_count=3`, `out_ovf=0`.
  - `out_valid` is high exactly 1 cycle, the cycle after the last beat.
- **Saturate mode:** `ACC_WIDTH=17`, `SATURATE=1`, same three beats.
  - Expect `out_sum=131071` and `out_ovf=1`.
  - A following burst of a single last beat of 6 gives `out_sum=6`, `out_ovf=0`.
- **Wrap mode:** `ACC_WIDTH=17`, `SATURATE=0`, same three beats.
  - Expect `out_sum=64003` and `out_ovf=1`.
- **Backpressure:** single-beat burst `in_prod=100`, `in_last=1`, `out_ready=0` for 4 cycles.
  - `out_valid=1` and `out_sum=100` stay stable and `in_ready=0` throughout.
  - Raising `out_ready` with a queued last beat of 7 gives `out_sum=7` the next cycle, with `out_valid` staying high.
- **Back-to-back with bubbles:** beats 10, idle, 20 with last, then immediately 5 with last, `out_ready=1`.
  - Results are 30 with count 2, then 5 with count 1, on consecutive cycles.
- **Reset mid-burst:** beats 1000 and 2000 (not last), `rst_n=0` for 1 cycle, then a last beat of 3.
  - Expect `out_sum=3`, `out_count=1`.
  - All outputs are 0 during reset.

Source files
------------

// File: rtl/product_accumulator.sv
// Accumulates a burst of 16-bit unsigned products, terminated by a last beat,
// into a sum, a term count and an overflow flag behind a valid/ready handshake.
module product_accumulator #(
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_prod,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  localparam logic S_ACC  = 1'b0;
  localparam logic S_HOLD = 1'b1;
  localparam int   SUM_WIDTH = ACC_WIDTH + 1;

  logic                 state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;

  logic [SUM_WIDTH-1:0] sum;
  logic                 carry;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 ovf_next;
  logic                 accept;

  // A pending result can be replaced in the same cycle it is consumed.
  assign in_ready  = rst_n && ((state == S_ACC) || out_ready);
  assign out_valid = (state == S_HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    sum      = SUM_WIDTH'(acc) + SUM_WIDTH'(in_prod);
    carry    = sum[ACC_WIDTH];
    acc_next = sum[ACC_WIDTH-1:0];
    if (carry && SATURATE) begin
      acc_next = '1;
    end
    ovf_next = ovf | carry;
    cnt_next = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if ((state == S_HOLD) && out_ready) begin
        state <= S_ACC;
      end
      if (accept) begin
        if (in_last) begin
          out_sum   <= acc_next;
          out_count <= cnt_next;
          out_ovf   <= ovf_next;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
          state     <= S_HOLD;
        end else begin
          acc <= acc_next;
          cnt <= cnt_next;
          ovf <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Drives three accumulator configurations from shared inputs and checks them
// against a burst-level model built from true sums and beat counts.
module tb_product_accumulator;

  localparam int  NCFG = 3;
  localparam int  CFG_W   [NCFG] = '{24, 17, 17};
  localparam bit  CFG_SAT [NCFG] = '{1'b1, 1'b1, 1'b0};
  localparam int  CFG_CW  [NCFG] = '{8, 8, 3};

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        rdy0, rdy1, rdy2;
  logic        vld0, vld1, vld2;
  logic [23:0] sum0;
  logic [16:0] sum1, sum2;
  logic [7:0]  cnt0, cnt1;
  logic [2:0]  cnt2;
  logic        ovf0, ovf1, ovf2;

  int testCount = 0;
  int failCount = 0;
  bit cmpEnable = 1'b0;

  product_accumulator #(.ACC_WIDTH(24), .CNT_WIDTH(8), .SATURATE(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_prod(in_prod), .in_last(in_last), .out_valid(vld0), .out_ready(out_ready),
    .out_sum(sum0), .out_count(cnt0), .out_ovf(ovf0)
  );

  product_accumulator #(.ACC_WIDTH(17), .CNT_WIDTH(8), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_prod(in_prod), .in_last(in_last), .out_valid(vld1), .out_ready(out_ready),
    .out_sum(sum1), .out_count(cnt1), .out_ovf(ovf1)
  );

  product_accumulator #(.ACC_WIDTH(17), .CNT_WIDTH(3), .SATURATE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_prod(in_prod), .in_last(in_last), .out_valid(vld2), .out_ready(out_ready),
    .out_sum(sum2), .out_count(cnt2), .out_ovf(ovf2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a burst is just its true (unbounded) sum and its beat count.
  longint burstSum;
  int     burstLen;
  bit     expValid;
  longint expSum [NCFG];
  longint expCnt [NCFG];
  bit     expOvf [NCFG];
  bit     expRdy;

  initial begin
    burstSum = 0;
    burstLen = 0;
    expValid = 1'b0;
    for (int k = 0; k < NCFG; k++) begin
      expSum[k] = 0;
      expCnt[k] = 0;
      expOvf[k] = 1'b0;
    end
  end

  always @(posedge clk) begin
    longint maxv;
    longint cmax;
    bit     take;
    if (!rst_n) begin
      burstSum = 0;
      burstLen = 0;
      expValid = 1'b0;
      for (int k = 0; k < NCFG; k++) begin
        expSum[k] = 0;
        expCnt[k] = 0;
        expOvf[k] = 1'b0;
      end
    end else begin
      take = in_valid && (!expValid || out_ready);
      if (expValid && out_ready) expValid = 1'b0;
      if (take) begin
        burstSum = burstSum + longint'(in_prod);
        burstLen = burstLen + 1;
        if (in_last) begin
          for (int k = 0; k < NCFG; k++) begin
            maxv = (longint'(1) << CFG_W[k]) - 1;
            cmax = (longint'(1) << CFG_CW[k]) - 1;
            expOvf[k] = (burstSum > maxv);
            if (CFG_SAT[k]) expSum[k] = (burstSum > maxv) ? maxv : burstSum;
            else            expSum[k] = burstSum & maxv;
            expCnt[k] = (longint'(burstLen) > cmax) ? cmax : longint'(burstLen);
          end
          expValid = 1'b1;
          burstSum = 0;
          burstLen = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmpEnable) begin
      expRdy = rst_n && (!expValid || out_ready);
      checkOutput("in_ready0", 64'(rdy0), 64'(expRdy));
      checkOutput("in_ready1", 64'(rdy1), 64'(expRdy));
      checkOutput("in_ready2", 64'(rdy2), 64'(expRdy));
      checkOutput("out_valid0", 64'(vld0), 64'(expValid));
      checkOutput("out_valid1", 64'(vld1), 64'(expValid));
      checkOutput("out_valid2", 64'(vld2), 64'(expValid));
      checkOutput("out_sum0", 64'(sum0), expSum[0]);
      checkOutput("out_sum1", 64'(sum1), expSum[1]);
      checkOutput("out_sum2", 64'(sum2), expSum[2]);
      checkOutput("out_count0", 64'(cnt0), expCnt[0]);
      checkOutput("out_count1", 64'(cnt1), expCnt[1]);
      checkOutput("out_count2", 64'(cnt2), expCnt[2]);
      checkOutput("out_ovf0", 64'(ovf0), 64'(expOvf[0]));
      checkOutput("out_ovf1", 64'(ovf1), 64'(expOvf[1]));
      checkOutput("out_ovf2", 64'(ovf2), 64'(expOvf[2]));
    end
  end

  // Holds the given inputs across one rising edge; returns shortly after it.
  task automatic applyStimulus(input logic v, input logic [15:0] p, input logic l, input logic r);
    in_valid  = v;
    in_prod   = p;
    in_last   = l;
    out_ready = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [15:0] prod;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    applyStimulus(0, 0, 0, 0);
    cmpEnable = 1'b1;
    applyStimulus(0, 0, 0, 1);
    checkOutput("reset out_valid", 64'(vld0), 64'd0);
    checkOutput("reset out_sum", 64'(sum0), 64'd0);
    checkOutput("reset out_count", 64'(cnt0), 64'd0);
    checkOutput("reset in_ready", 64'(rdy0), 64'd0);

    // Basic, saturate and wrap bursts share the same three beats.
    rst_n = 1'b1;
    applyStimulus(1, 16'd65025, 0, 1);
    applyStimulus(1, 16'd65025, 0, 1);
    applyStimulus(1, 16'd65025, 1, 1);
    checkOutput("basic out_valid", 64'(vld0), 64'd1);
    checkOutput("basic out_sum", 64'(sum0), 64'd195075);
    checkOutput("basic out_count", 64'(cnt0), 64'd3);
    checkOutput("basic out_ovf", 64'(ovf0), 64'd0);
    checkOutput("sat out_sum", 64'(sum1), 64'd131071);
    checkOutput("sat out_ovf", 64'(ovf1), 64'd1);
    checkOutput("wrap out_sum", 64'(sum2), 64'd64003);
    checkOutput("wrap out_ovf", 64'(ovf2), 64'd1);
    applyStimulus(1, 16'd6, 1, 1);
    checkOutput("sat fresh out_sum", 64'(sum1), 64'd6);
    checkOutput("sat fresh out_ovf", 64'(ovf1), 64'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("release out_valid", 64'(vld0), 64'd0);

    applyStimulus(1, 16'd100, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 16'd7, 1, 0);
      checkOutput("bp out_valid", 64'(vld0), 64'd1);
      checkOutput("bp out_sum", 64'(sum0), 64'd100);
      checkOutput("bp in_ready", 64'(rdy0), 64'd0);
    end
    applyStimulus(1, 16'd7, 1, 1);
    checkOutput("bp replace out_sum", 64'(sum0), 64'd7);
    checkOutput("bp replace out_valid", 64'(vld0), 64'd1);
    applyStimulus(0, 0, 0, 1);

    applyStimulus(1, 16'd10, 0, 1);
    applyStimulus(0, 16'd0, 0, 1);
    applyStimulus(1, 16'd20, 1, 1);
    checkOutput("b2b first out_sum", 64'(sum0), 64'd30);
    checkOutput("b2b first out_count", 64'(cnt0), 64'd2);
    applyStimulus(1, 16'd5, 1, 1);
    checkOutput("b2b second out_sum", 64'(sum0), 64'd5);
    checkOutput("b2b second out_count", 64'(cnt0), 64'd1);
    checkOutput("b2b second out_valid", 64'(vld0), 64'd1);
    applyStimulus(0, 0, 0, 1);

    applyStimulus(1, 16'd1000, 0, 1);
    applyStimulus(1, 16'd2000, 0, 1);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 1);
    checkOutput("midreset out_valid", 64'(vld0), 64'd0);
    checkOutput("midreset out_sum", 64'(sum0), 64'd0);
    checkOutput("midreset out_count", 64'(cnt0), 64'd0);
    checkOutput("midreset in_ready", 64'(rdy0), 64'd0);
    rst_n = 1'b1;
    applyStimulus(1, 16'd3, 1, 1);
    checkOutput("after reset out_sum", 64'(sum0), 64'd3);
    checkOutput("after reset out_count", 64'(cnt0), 64'd1);

    // Nine beats overrun the 3-bit counter of the wrap instance.
    for (int i = 0; i < 9; i++) applyStimulus(1, 16'd1, (i == 8), 1);
    checkOutput("cnt sat out_count2", 64'(cnt2), 64'd7);
    checkOutput("cnt sat out_count0", 64'(cnt0), 64'd9);
    checkOutput("cnt sat out_sum2", 64'(sum2), 64'd9);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       prod = 16'hFFFF;
        1:       prod = 16'($urandom_range(0, 15));
        default: prod = 16'($urandom);
      endcase
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus($urandom_range(0, 3) != 0, prod, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) != 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
